// File: rtl/bus_monitor_pkg.sv
// rtl/bus_monitor_pkg.sv - shared FSM state type, halt-cause codes and cycle-counter helper
package bus_monitor_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ADDR    = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    localparam logic [31:0] CYCLE_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CYCLE_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/bus_monitor_if.sv
// rtl/bus_monitor_if.sv - core bus tap and trace-log signals between a core and bus_monitor
interface bus_monitor_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LOG_DEPTH = 8
);
    localparam int CNT_W = $clog2(LOG_DEPTH) + 1;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_out;
    logic              we;
    logic              halt;
    logic [1:0]        halt_cause;
    logic              log_valid;
    logic [ADDR_W-1:0] log_addr;
    logic [DATA_W-1:0] log_data;
    logic              log_ready;
    logic [CNT_W-1:0]  log_count;
    logic              overflow;
    logic [31:0]       cycle_count;

    modport master (
        output address, data_out, we, log_ready,
        input  halt, halt_cause, log_valid, log_addr, log_data, log_count, overflow, cycle_count
    );

    modport slave (
        input  address, data_out, we, log_ready,
        output halt, halt_cause, log_valid, log_addr, log_data, log_count, overflow, cycle_count
    );

endinterface

// File: rtl/bus_monitor_trace_fifo.sv
// rtl/bus_monitor_trace_fifo.sv - show-ahead trace FIFO; head entry is readable without a pop
module trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;
    logic             push_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/bus_monitor.sv
// rtl/bus_monitor.sv - watches core writes, logs MMIO stores and ends the run on halt address or timeout
module bus_monitor
    import bus_monitor_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] HALT_ADDR = 'hFFC,
    parameter int                MMIO_BIT  = 11,
    parameter int                LOG_DEPTH = 8,
    parameter int                TIMEOUT   = 2000
) (
    input  logic          clk,
    input  logic          reset,
    bus_monitor_if.slave  bus
);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    state_t      state_q;
    logic [1:0]  cause_q;
    logic [31:0] cycle_q;
    logic [31:0] cycle_d;
    logic        overflow_q;

    logic        in_run;
    logic        addr_hit;
    logic        timeout_hit;
    logic        capture;
    logic        drop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [ADDR_W+DATA_W-1:0] head;

    assign in_run      = (state_q == ST_RUN);
    assign addr_hit    = (bus.address == HALT_ADDR);
    assign timeout_hit = (cycle_q == TIMEOUT_LAST);
    assign capture     = in_run && bus.we && bus.address[MMIO_BIT] && !addr_hit;
    // Full implies non-empty, so log_ready alone decides whether a pop makes room.
    assign drop        = capture && fifo_full && !bus.log_ready;
    assign cycle_d     = in_run ? sat_inc(cycle_q) : cycle_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cause_q    <= CAUSE_NONE;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            if (drop) overflow_q <= 1'b1;
            case (state_q)
                ST_RUN: begin
                    if (addr_hit) begin
                        state_q <= ST_HALTED;
                        cause_q <= CAUSE_ADDR;
                    end else if (timeout_hit) begin
                        state_q <= ST_HALTED;
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end
                ST_HALTED: state_q <= ST_HALTED;
                default:   state_q <= ST_RUN;
            endcase
        end
    end

    trace_fifo #(
        .WIDTH(ADDR_W + DATA_W),
        .DEPTH(LOG_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .push_i      (capture),
        .push_data_i ({bus.address, bus.data_out}),
        .pop_i       (bus.log_ready),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (bus.log_count)
    );

    assign bus.halt        = (state_q == ST_HALTED);
    assign bus.halt_cause  = cause_q;
    assign bus.overflow    = overflow_q;
    assign bus.cycle_count = cycle_q;
    assign bus.log_valid   = !fifo_empty;
    assign bus.log_addr    = head[ADDR_W+DATA_W-1:DATA_W];
    assign bus.log_data    = head[DATA_W-1:0];

endmodule

// File: tb/tb_bus_monitor.sv
// tb/tb_bus_monitor.sv - directed stimulus with a queue-based reference model checked every cycle
module tb_bus_monitor;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 100;
    localparam logic [31:0] HALT = 32'hFFC;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    bus_monitor_if #(.ADDR_W(32), .DATA_W(32), .LOG_DEPTH(DEPTH)) bus ();

    bus_monitor #(
        .ADDR_W(32), .DATA_W(32), .HALT_ADDR(HALT), .MMIO_BIT(11),
        .LOG_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the log is a plain queue, the run is a cycle tally and a halted flag.
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] m_cycle;
    bit          m_halt;
    logic [1:0]  m_cause;
    bit          m_ovf;

    always @(posedge clk or posedge reset) begin : model
        bit run, pop, cap;
        int sz;
        if (reset) begin
            q_addr.delete();
            q_data.delete();
            m_cycle = 0;
            m_halt  = 0;
            m_cause = 0;
            m_ovf   = 0;
        end else begin
            sz  = q_addr.size();
            run = !m_halt;
            pop = (sz > 0) && bus.log_ready;
            cap = run && bus.we && bus.address[11] && (bus.address != HALT);
            if (pop) begin
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
            if (cap) begin
                if (sz < DEPTH || pop) begin
                    q_addr.push_back(bus.address);
                    q_data.push_back(bus.data_out);
                end else begin
                    m_ovf = 1;
                end
            end
            if (run) begin
                if (bus.address == HALT) begin
                    m_halt = 1; m_cause = 2'd1;
                end else if (m_cycle + 1 == TIMEOUT) begin
                    m_halt = 1; m_cause = 2'd2;
                end
                if (m_cycle != 32'hFFFF_FFFF) m_cycle = m_cycle + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("halt",        bus.halt,        m_halt);
            check("halt_cause",  bus.halt_cause,  m_cause);
            check("overflow",    bus.overflow,    m_ovf);
            check("cycle_count", bus.cycle_count, m_cycle);
            check("log_count",   bus.log_count,   q_addr.size());
            check("log_valid",   bus.log_valid,   q_addr.size() > 0);
            if (q_addr.size() > 0) begin
                check("log_addr", bus.log_addr, q_addr[0]);
                check("log_data", bus.log_data, q_data[0]);
            end
        end
    end

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        bus.address   = a;
        bus.data_out  = d;
        bus.we        = w;
        bus.log_ready = r;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0, r);
    endtask

    task automatic pulse_reset();
        bus.address = 0; bus.data_out = 0; bus.we = 0; bus.log_ready = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.address = 0; bus.data_out = 0; bus.we = 0; bus.log_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_halt",  bus.halt, 0);
        check("rst_cause", bus.halt_cause, 0);
        check("rst_valid", bus.log_valid, 0);
        check("rst_count", bus.log_count, 0);
        check("rst_ovf",   bus.overflow, 0);
        check("rst_cycle", bus.cycle_count, 0);
        reset = 1'b0;

        // two writes drained in order
        step(32'h800, 32'hA5, 1, 1);
        check("t1_addr0", bus.log_addr, 32'h800);
        check("t1_data0", bus.log_data, 32'hA5);
        step(32'h804, 32'h5A, 1, 1);
        check("t1_addr1", bus.log_addr, 32'h804);
        check("t1_data1", bus.log_data, 32'h5A);
        check("t1_count", bus.log_count, 1);
        idle(3, 1);
        check("t1_empty", bus.log_valid, 0);
        check("t1_ovf",   bus.overflow, 0);
        pulse_reset();

        // nine writes into an eight-deep log
        for (int i = 0; i < 9; i++) step(32'h800 + 4 * i, i, 1, 0);
        check("t2_count", bus.log_count, 8);
        check("t2_ovf",   bus.overflow, 1);
        for (int i = 0; i < 8; i++) begin
            check("t2_drain", bus.log_addr, 32'h800 + 4 * i);
            step(32'h0, 32'h0, 0, 1);
        end
        check("t2_drained", bus.log_count, 0);
        pulse_reset();

        // full log with a simultaneous capture and pop
        for (int i = 0; i < 8; i++) step(32'h800 + 4 * i, 32'h100 + i, 1, 0);
        step(32'h840, 32'h77, 1, 1);
        check("t3_count", bus.log_count, 8);
        check("t3_ovf",   bus.overflow, 0);
        check("t3_head",  bus.log_addr, 32'h804);
        idle(9, 1);
        pulse_reset();

        // halt address at cycle 50
        idle(50, 0);
        check("t4_cyc50", bus.cycle_count, 50);
        step(HALT, 32'h1234, 1, 0);
        check("t4_halt",  bus.halt, 1);
        check("t4_cause", bus.halt_cause, 1);
        check("t4_cycle", bus.cycle_count, 51);
        check("t4_nolog", bus.log_count, 0);
        for (int i = 0; i < 3; i++) step(32'h800, 32'h99, 1, 0);
        check("t4_ignored", bus.log_count, 0);
        check("t4_frozen",  bus.cycle_count, 51);
        pulse_reset();

        // reset while halted holding three entries
        for (int i = 0; i < 3; i++) step(32'h800 + 4 * i, i, 1, 0);
        step(HALT, 32'h0, 0, 0);
        check("t5_halt",  bus.halt, 1);
        check("t5_count", bus.log_count, 3);
        reset = 1'b1;
        @(negedge clk);
        check("t5_r_halt",  bus.halt, 0);
        check("t5_r_cause", bus.halt_cause, 0);
        check("t5_r_valid", bus.log_valid, 0);
        check("t5_r_count", bus.log_count, 0);
        check("t5_r_cycle", bus.cycle_count, 0);
        reset = 1'b0;
        idle(1, 0);
        check("t5_restart", bus.cycle_count, 1);
        check("t5_run",     bus.halt, 0);
        pulse_reset();

        // timeout, then draining while halted
        step(32'h800, 32'h11, 1, 0);
        step(32'h804, 32'h22, 1, 0);
        idle(97, 0);
        check("t6_cyc99", bus.cycle_count, 99);
        check("t6_run",   bus.halt, 0);
        idle(1, 0);
        check("t6_halt",  bus.halt, 1);
        check("t6_cause", bus.halt_cause, 2);
        check("t6_cycle", bus.cycle_count, 100);
        check("t6_kept",  bus.log_count, 2);
        idle(1, 1);
        check("t6_pop",   bus.log_addr, 32'h804);
        idle(1, 1);
        check("t6_drained", bus.log_count, 0);
        idle(3, 0);
        check("t6_frozen", bus.cycle_count, 100);
        pulse_reset();

        // halt address on the timeout edge
        idle(99, 0);
        step(HALT, 32'h0, 0, 0);
        check("t7_cause", bus.halt_cause, 1);
        check("t7_cycle", bus.cycle_count, 100);
        idle(2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
